csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports:
- clk_i  in  1  system clock, all state on rising edge.
- n_rst_i  in  1  synchronous reset, active-high (1 = reset).
- raddr_i  in  12  CSR read address.
- rdata_o  out  32  CSR read data, combinational.
- we_i  in  1  CSR write enable.
- waddr_i  in  12  CSR write address.
- wdata_i  in  32  CSR write data, post CSRRW/S/C arithmetic.
- instret_i  in  1  one instruction retired this cycle.
- irq_external_i  in  1  external interrupt level.
- irq_timer_i  in  1  timer interrupt level.
- irq_software_i  in  1  software interrupt level.
- ie_type_i  in  1  trap is interrupt (1) or exception (0).
- set_cause_i  in  1  load mcause.
- trap_cause_i  in  4  cause code.
- set_epc_i  in  1  load mepc.
- epc_i  in  32  trapping PC.
- set_mtval_i  in  1  load mtval.
- mtval_i  in  32  trap value.
- mstatus_ie_clear_i  in  1  trap entry.
- mstatus_ie_set_i  in  1  mret.
- mstatus_ie_o  out  1  mstatus.MIE.
- mie_external_o, mie_timer_o, mie_sw_o  out  1 each  mie bits 11/7/3.
- mip_external_o, mip_timer_o, mip_sw_o  out  1 each  mip bits 11/7/3.
- mtvec_o  out  32  mtvec.
- epc_o  out  32  mepc.

Function
REQ-003 SHALL implement (addr): mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, mhartid 0xF14.
REQ-004 SHALL return rdata_o = current register value (no write bypass); unmapped address reads 0.
REQ-005 SHALL hold only mstatus bits 3 (MIE), 7 (MPIE), 12:11 (MPP, read as 2'b11, not writable); other bits read 0.
REQ-006 SHALL hold only mie bits 3/7/11 writable; others read 0.
REQ-007 SHALL register mip bits 11/7/3 from irq_external_i/irq_timer_i/irq_software_i every cycle (1-cycle latency); mip writes ignored.
REQ-008 SHALL read misa as 0x40000100 (RV32I), mhartid as 0; writes ignored.
REQ-009 SHALL store mtvec with bit 1 forced 0 (modes direct 00 / vectored 01 only).
REQ-010 SHALL store mepc with bits 1:0 forced 0, from software write or epc_i.
REQ-011 SHALL load mcause = {ie_type_i, 27'b0, trap_cause_i} when set_cause_i.
REQ-012 SHALL load mtval from mtval_i when set_mtval_i.
REQ-013 On mstatus_ie_clear_i: MPIE <= MIE, MIE <= 0, next cycle.
REQ-014 On mstatus_ie_set_i: MIE <= MPIE, MPIE <= 1, next cycle.
REQ-015 If clear and set asserted together, clear SHALL win.
REQ-016 Trap-port updates (REQ-010..015) SHALL win over a software write to the same CSR in the same cycle; writes to other CSRs that cycle proceed.
REQ-017 mcycle (64-bit) SHALL increment by 1 every non-reset cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-018 minstret (64-bit) SHALL increment by 1 on cycles with instret_i=1, same wrap.
REQ-019 Software write to a counter half SHALL replace that half with wdata_i, suppressing that cycle's increment for the whole counter; other half unchanged.
REQ-020 Increment carry from low to high half SHALL occur in the same cycle.

Reset
REQ-021 On n_rst_i=1 at a clock edge all CSRs SHALL clear to 0 except misa/mhartid/MPP constants; outputs all 0 the following cycle.
REQ-022 Reset SHALL override any simultaneous write, trap update or increment.

Verification
REQ-023 Write 0x305 with 0x8000_0003 -> mtvec_o = 0x8000_0001 next cycle.
REQ-024 MIE=1, MPIE=0, pulse mstatus_ie_clear_i with set_cause_i, ie_type_i=1, cause 4'hB, set_epc_i, epc_i=0x102 -> MIE=0, MPIE=1, mcause=0x8000_000B, mepc=0x100; then mstatus_ie_set_i -> MIE=1, MPIE=1.
REQ-025 Write mepc=0x200 and set_epc_i with epc_i=0x300 same cycle -> mepc=0x300.
REQ-026 Write mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycles read 0x0000_0000 low, 0x1 high.
REQ-027 Raise irq_timer_i with mie bit7=1 -> mip_timer_o=1 exactly one cycle later; mie_timer_o=1 throughout.
REQ-028 Assert n_rst_i mid-run with we_i=1 to mscratch and instret_i=1 -> all CSRs reset values, mscratch=0, minstret=0.

Source files
------------

// File: rtl/csr_file_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_file_if
// Description : CSR read/write bus between the core and the machine CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_file_if;
    logic [11:0] raddr_i;
    logic [31:0] rdata_o;
    logic        we_i;
    logic [11:0] waddr_i;
    logic [31:0] wdata_i;

    modport master (output raddr_i, we_i, waddr_i, wdata_i, input rdata_o);
    modport slave  (input raddr_i, we_i, waddr_i, wdata_i, output rdata_o);
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_file
// Description : RV32 machine-mode CSR file with trap ports and 64-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_file (
    input  wire logic        clk_i,
    input  wire logic        n_rst_i,
    csr_file_if.slave        bus,
    input  wire logic        instret_i,
    input  wire logic        irq_external_i,
    input  wire logic        irq_timer_i,
    input  wire logic        irq_software_i,
    input  wire logic        ie_type_i,
    input  wire logic        set_cause_i,
    input  wire logic [3:0]  trap_cause_i,
    input  wire logic        set_epc_i,
    input  wire logic [31:0] epc_i,
    input  wire logic        set_mtval_i,
    input  wire logic [31:0] mtval_i,
    input  wire logic        mstatus_ie_clear_i,
    input  wire logic        mstatus_ie_set_i,
    output logic             mstatus_ie_o,
    output logic             mie_external_o,
    output logic             mie_timer_o,
    output logic             mie_sw_o,
    output logic             mip_external_o,
    output logic             mip_timer_o,
    output logic             mip_sw_o,
    output logic [31:0]      mtvec_o,
    output logic [31:0]      epc_o
);

    localparam logic [11:0] c_MSTATUS   = 12'h300;
    localparam logic [11:0] c_MISA      = 12'h301;
    localparam logic [11:0] c_MIE       = 12'h304;
    localparam logic [11:0] c_MTVEC     = 12'h305;
    localparam logic [11:0] c_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_MEPC      = 12'h341;
    localparam logic [11:0] c_MCAUSE    = 12'h342;
    localparam logic [11:0] c_MTVAL     = 12'h343;
    localparam logic [11:0] c_MIP       = 12'h344;
    localparam logic [11:0] c_MCYCLE    = 12'hB00;
    localparam logic [11:0] c_MINSTRET  = 12'hB02;
    localparam logic [11:0] c_MCYCLEH   = 12'hB80;
    localparam logic [11:0] c_MINSTRETH = 12'hB82;
    localparam logic [11:0] c_MHARTID   = 12'hF14;
    localparam logic [31:0] c_MISA_VAL  = 32'h4000_0100;

    logic        r_status_mie, r_status_mpie;
    logic        r_mie_ext, r_mie_tim, r_mie_sw;
    logic        r_mip_ext, r_mip_tim, r_mip_sw;
    logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [63:0] r_mcycle, r_minstret;

    logic [63:0] w_mcycle_next, w_minstret_next;
    logic [31:0] w_rdata;
    logic        w_wr_mstatus, w_wr_mie, w_wr_mtvec, w_wr_mscratch, w_wr_mepc;
    logic        w_wr_mcause, w_wr_mtval, w_wr_mcycle, w_wr_mcycleh;
    logic        w_wr_minstret, w_wr_minstreth;

    assign w_wr_mstatus   = bus.we_i && (bus.waddr_i == c_MSTATUS);
    assign w_wr_mie       = bus.we_i && (bus.waddr_i == c_MIE);
    assign w_wr_mtvec     = bus.we_i && (bus.waddr_i == c_MTVEC);
    assign w_wr_mscratch  = bus.we_i && (bus.waddr_i == c_MSCRATCH);
    assign w_wr_mepc      = bus.we_i && (bus.waddr_i == c_MEPC);
    assign w_wr_mcause    = bus.we_i && (bus.waddr_i == c_MCAUSE);
    assign w_wr_mtval     = bus.we_i && (bus.waddr_i == c_MTVAL);
    assign w_wr_mcycle    = bus.we_i && (bus.waddr_i == c_MCYCLE);
    assign w_wr_mcycleh   = bus.we_i && (bus.waddr_i == c_MCYCLEH);
    assign w_wr_minstret  = bus.we_i && (bus.waddr_i == c_MINSTRET);
    assign w_wr_minstreth = bus.we_i && (bus.waddr_i == c_MINSTRETH);

    // A write to either half freezes the whole counter for that cycle
    always_comb begin
        w_mcycle_next   = r_mcycle + 64'd1;
        w_minstret_next = r_minstret + {63'd0, instret_i};
        if (w_wr_mcycle)
            w_mcycle_next = {r_mcycle[63:32], bus.wdata_i};
        else if (w_wr_mcycleh)
            w_mcycle_next = {bus.wdata_i, r_mcycle[31:0]};
        if (w_wr_minstret)
            w_minstret_next = {r_minstret[63:32], bus.wdata_i};
        else if (w_wr_minstreth)
            w_minstret_next = {bus.wdata_i, r_minstret[31:0]};
    end

    always_ff @(posedge clk_i) begin
        if (n_rst_i) begin
            r_status_mie  <= 1'b0;
            r_status_mpie <= 1'b0;
            r_mie_ext     <= 1'b0;
            r_mie_tim     <= 1'b0;
            r_mie_sw      <= 1'b0;
            r_mip_ext     <= 1'b0;
            r_mip_tim     <= 1'b0;
            r_mip_sw      <= 1'b0;
            r_mtvec       <= 32'd0;
            r_mscratch    <= 32'd0;
            r_mepc        <= 32'd0;
            r_mcause      <= 32'd0;
            r_mtval       <= 32'd0;
            r_mcycle      <= 64'd0;
            r_minstret    <= 64'd0;
        end else begin
            r_mip_ext <= irq_external_i;
            r_mip_tim <= irq_timer_i;
            r_mip_sw  <= irq_software_i;

            // Trap entry beats mret, and both beat a software write
            if (mstatus_ie_clear_i) begin
                r_status_mpie <= r_status_mie;
                r_status_mie  <= 1'b0;
            end else if (mstatus_ie_set_i) begin
                r_status_mie  <= r_status_mpie;
                r_status_mpie <= 1'b1;
            end else if (w_wr_mstatus) begin
                r_status_mie  <= bus.wdata_i[3];
                r_status_mpie <= bus.wdata_i[7];
            end

            if (w_wr_mie) begin
                r_mie_ext <= bus.wdata_i[11];
                r_mie_tim <= bus.wdata_i[7];
                r_mie_sw  <= bus.wdata_i[3];
            end

            if (w_wr_mtvec)
                r_mtvec <= bus.wdata_i & 32'hFFFF_FFFD;
            if (w_wr_mscratch)
                r_mscratch <= bus.wdata_i;

            if (set_epc_i)
                r_mepc <= epc_i & 32'hFFFF_FFFC;
            else if (w_wr_mepc)
                r_mepc <= bus.wdata_i & 32'hFFFF_FFFC;

            if (set_cause_i)
                r_mcause <= {ie_type_i, 27'd0, trap_cause_i};
            else if (w_wr_mcause)
                r_mcause <= bus.wdata_i;

            if (set_mtval_i)
                r_mtval <= mtval_i;
            else if (w_wr_mtval)
                r_mtval <= bus.wdata_i;

            r_mcycle   <= w_mcycle_next;
            r_minstret <= w_minstret_next;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (bus.raddr_i)
            c_MSTATUS:   w_rdata = {19'd0, 2'b11, 3'd0, r_status_mpie, 3'd0, r_status_mie, 3'd0};
            c_MISA:      w_rdata = c_MISA_VAL;
            c_MIE:       w_rdata = {20'd0, r_mie_ext, 3'd0, r_mie_tim, 3'd0, r_mie_sw, 3'd0};
            c_MTVEC:     w_rdata = r_mtvec;
            c_MSCRATCH:  w_rdata = r_mscratch;
            c_MEPC:      w_rdata = r_mepc;
            c_MCAUSE:    w_rdata = r_mcause;
            c_MTVAL:     w_rdata = r_mtval;
            c_MIP:       w_rdata = {20'd0, r_mip_ext, 3'd0, r_mip_tim, 3'd0, r_mip_sw, 3'd0};
            c_MCYCLE:    w_rdata = r_mcycle[31:0];
            c_MINSTRET:  w_rdata = r_minstret[31:0];
            c_MCYCLEH:   w_rdata = r_mcycle[63:32];
            c_MINSTRETH: w_rdata = r_minstret[63:32];
            c_MHARTID:   w_rdata = 32'd0;
            default:     w_rdata = 32'd0;
        endcase
    end

    assign bus.rdata_o    = w_rdata;
    assign mstatus_ie_o   = r_status_mie;
    assign mie_external_o = r_mie_ext;
    assign mie_timer_o    = r_mie_tim;
    assign mie_sw_o       = r_mie_sw;
    assign mip_external_o = r_mip_ext;
    assign mip_timer_o    = r_mip_tim;
    assign mip_sw_o       = r_mip_sw;
    assign mtvec_o        = r_mtvec;
    assign epc_o          = r_mepc;

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_file
// Description : Directed scoreboard bench for the machine CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;
    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        instret_i, irq_external_i, irq_timer_i, irq_software_i;
    logic        ie_type_i, set_cause_i, set_epc_i, set_mtval_i;
    logic [3:0]  trap_cause_i;
    logic [31:0] epc_i, mtval_i;
    logic        mstatus_ie_clear_i, mstatus_ie_set_i;
    logic        mstatus_ie_o, mie_external_o, mie_timer_o, mie_sw_o;
    logic        mip_external_o, mip_timer_o, mip_sw_o;
    logic [31:0] mtvec_o, epc_o;

    csr_file_if bus ();

    csr_file dut (
        .clk_i              (clk_i),
        .n_rst_i            (n_rst_i),
        .bus                (bus),
        .instret_i          (instret_i),
        .irq_external_i     (irq_external_i),
        .irq_timer_i        (irq_timer_i),
        .irq_software_i     (irq_software_i),
        .ie_type_i          (ie_type_i),
        .set_cause_i        (set_cause_i),
        .trap_cause_i       (trap_cause_i),
        .set_epc_i          (set_epc_i),
        .epc_i              (epc_i),
        .set_mtval_i        (set_mtval_i),
        .mtval_i            (mtval_i),
        .mstatus_ie_clear_i (mstatus_ie_clear_i),
        .mstatus_ie_set_i   (mstatus_ie_set_i),
        .mstatus_ie_o       (mstatus_ie_o),
        .mie_external_o     (mie_external_o),
        .mie_timer_o        (mie_timer_o),
        .mie_sw_o           (mie_sw_o),
        .mip_external_o     (mip_external_o),
        .mip_timer_o        (mip_timer_o),
        .mip_sw_o           (mip_sw_o),
        .mtvec_o            (mtvec_o),
        .epc_o              (epc_o)
    );

    always #50 clk_i = ~clk_i;

    logic [31:0] exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] e, input string tag);
        bus.raddr_i = addr;
        push(e);
        #1;
        check(tag, bus.rdata_o);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        bus.we_i    = 1'b1;
        bus.waddr_i = addr;
        bus.wdata_i = data;
        tick();
        bus.we_i    = 1'b0;
    endtask

    initial begin
        n_rst_i = 1'b1;
        {instret_i, irq_external_i, irq_timer_i, irq_software_i} = '0;
        {ie_type_i, set_cause_i, set_epc_i, set_mtval_i} = '0;
        {mstatus_ie_clear_i, mstatus_ie_set_i} = '0;
        trap_cause_i = '0; epc_i = '0; mtval_i = '0;
        bus.raddr_i = '0; bus.we_i = 1'b0; bus.waddr_i = '0; bus.wdata_i = '0;
        tick();
        tick();
        n_rst_i = 1'b0;

        // Reset state
        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        rd(12'h301, 32'h4000_0100, "rst_misa");
        rd(12'hF14, 32'h0, "rst_mhartid");
        rd(12'h7C0, 32'h0, "unmapped");
        rd(12'hB00, 32'h0, "rst_mcycle");
        push(32'h0); check("rst_mtvec_o", mtvec_o);
        push(32'h0); check("rst_ie_o", {31'd0, mstatus_ie_o});
        tick();
        rd(12'hB00, 32'h1, "mcycle_first_inc");

        // mtvec bit 1 forced low
        wr(12'h305, 32'h8000_0003);
        push(32'h8000_0001); check("mtvec_o", mtvec_o);
        rd(12'h305, 32'h8000_0001, "mtvec_rd");

        // Only mie 11/7/3 and mstatus MIE/MPIE writable; MPP constant
        wr(12'h304, 32'hFFFF_FFFF);
        rd(12'h304, 32'h0000_0888, "mie_rd");
        wr(12'h300, 32'h0000_0008);
        rd(12'h300, 32'h0000_1808, "mstatus_wr");

        // Trap entry
        mstatus_ie_clear_i = 1'b1; set_cause_i = 1'b1; ie_type_i = 1'b1;
        trap_cause_i = 4'hB; set_epc_i = 1'b1; epc_i = 32'h102;
        tick();
        mstatus_ie_clear_i = 1'b0; set_cause_i = 1'b0; ie_type_i = 1'b0; set_epc_i = 1'b0;
        rd(12'h300, 32'h0000_1880, "trap_mstatus");
        rd(12'h342, 32'h8000_000B, "trap_mcause");
        push(32'h100); check("trap_epc_o", epc_o);
        push(32'h0); check("trap_ie_o", {31'd0, mstatus_ie_o});

        // mret
        mstatus_ie_set_i = 1'b1;
        tick();
        mstatus_ie_set_i = 1'b0;
        rd(12'h300, 32'h0000_1888, "mret_mstatus");

        // Clear and set together: clear wins
        mstatus_ie_clear_i = 1'b1; mstatus_ie_set_i = 1'b1;
        tick();
        mstatus_ie_clear_i = 1'b0; mstatus_ie_set_i = 1'b0;
        rd(12'h300, 32'h0000_1880, "clr_set_mstatus");

        // Trap port beats software write to mepc; other CSR writes proceed
        set_epc_i = 1'b1; epc_i = 32'h300;
        wr(12'h341, 32'h200);
        rd(12'h341, 32'h300, "mepc_priority");
        epc_i = 32'h47;
        wr(12'h340, 32'hDEAD_BEEF);
        set_epc_i = 1'b0;
        rd(12'h340, 32'hDEAD_BEEF, "mscratch_with_trap");
        rd(12'h341, 32'h44, "mepc_align");

        set_mtval_i = 1'b1; mtval_i = 32'h1234_5678;
        tick();
        set_mtval_i = 1'b0;
        rd(12'h343, 32'h1234_5678, "mtval");

        // Read-only CSRs ignore writes
        wr(12'h344, 32'hFFFF_FFFF);
        rd(12'h344, 32'h0, "mip_wr_ignored");
        wr(12'h301, 32'h0);
        rd(12'h301, 32'h4000_0100, "misa_wr_ignored");

        // Interrupt pending register has one cycle of latency
        irq_timer_i = 1'b1;
        push(32'h0); check("mip_timer_pre", {31'd0, mip_timer_o});
        tick();
        push(32'h1); check("mip_timer_post", {31'd0, mip_timer_o});
        push(32'h1); check("mie_timer_o", {31'd0, mie_timer_o});
        rd(12'h344, 32'h0000_0080, "mip_rd");
        irq_timer_i = 1'b0;
        tick();
        push(32'h0); check("mip_timer_drop", {31'd0, mip_timer_o});

        // mcycle carry into high half
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_wr_lo");
        wr(12'hB80, 32'h0);
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_hold_lo");
        rd(12'hB80, 32'h0, "mcycleh_wr");
        tick();
        rd(12'hB00, 32'h0, "mcycle_wrap_lo");
        rd(12'hB80, 32'h1, "mcycle_carry_hi");

        // minstret: write suppresses increment, then counts retirements
        instret_i = 1'b1;
        wr(12'hB02, 32'h5);
        rd(12'hB02, 32'h5, "minstret_wr");
        tick();
        tick();
        instret_i = 1'b0;
        tick();
        rd(12'hB02, 32'h7, "minstret_count");
        instret_i = 1'b1;
        wr(12'hB02, 32'hFFFF_FFFF);
        tick();
        instret_i = 1'b0;
        rd(12'hB02, 32'h0, "minstret_wrap_lo");
        rd(12'hB82, 32'h1, "minstret_carry_hi");

        // Reset overrides simultaneous write and increment
        n_rst_i = 1'b1; instret_i = 1'b1;
        bus.we_i = 1'b1; bus.waddr_i = 12'h340; bus.wdata_i = 32'h55;
        tick();
        n_rst_i = 1'b0; instret_i = 1'b0; bus.we_i = 1'b0;
        rd(12'h340, 32'h0, "rst2_mscratch");
        rd(12'hB02, 32'h0, "rst2_minstret");
        rd(12'hB82, 32'h0, "rst2_minstreth");
        rd(12'hB80, 32'h0, "rst2_mcycleh");
        rd(12'h300, 32'h0000_1800, "rst2_mstatus");
        rd(12'h342, 32'h0, "rst2_mcause");
        rd(12'h343, 32'h0, "rst2_mtval");
        push(32'h0); check("rst2_mtvec_o", mtvec_o);
        push(32'h0); check("rst2_epc_o", epc_o);
        push(32'h0); check("rst2_mie_bits", {29'd0, mie_external_o, mie_timer_o, mie_sw_o});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
